// File: rtl/adc_acq_pkg.sv
// rtl/adc_acq_pkg.sv - shared types and limits for the ADC acquisition scheduler
package adc_acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } acq_state_e;

    localparam int ADC_DW       = 12;
    localparam int AVG_LOG2_MAX = 4;

endpackage

// File: rtl/adc_acq_accum.sv
// rtl/adc_acq_accum.sv - per-channel burst accumulator with shifted average output
// ADC_ACQ_MINMAX_EN adds running min/max of the burst.
module adc_acq_accum
    import adc_acq_pkg::*;
#(
    parameter int DW       = ADC_DW,
    parameter int AVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          clear,
    input  logic          add,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] avg
`ifdef ADC_ACQ_MINMAX_EN
    ,
    output logic [DW-1:0] burst_min,
    output logic [DW-1:0] burst_max
`endif
);

    localparam int AW = DW + AVG_LOG2;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] sum;

    // The average includes the sample arriving this cycle so the result is ready on the final strobe.
    assign sum = acc_q + AW'(data);
    assign avg = DW'(sum >> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (!rst_ni || clear) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= sum;
        end
    end

`ifdef ADC_ACQ_MINMAX_EN
    logic [DW-1:0] min_q;
    logic [DW-1:0] max_q;

    assign burst_min = (data < min_q) ? data : min_q;
    assign burst_max = (data > max_q) ? data : max_q;

    always_ff @(posedge clk) begin
        if (!rst_ni || clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (add) begin
            min_q <= burst_min;
            max_q <= burst_max;
        end
    end
`endif

endmodule

// File: rtl/adc_acq_ctrl.sv
// rtl/adc_acq_ctrl.sv - dual-channel ADC burst acquisition, averaging and result handshake
// Define ADC_ACQ_MINMAX_EN to add per-channel burst min/max outputs.
module adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int DW          = ADC_DW,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          cont_i,
    input  logic          abort_i,
    output logic          adc_en_o,
    input  logic          adc_update_i,
    input  logic [DW-1:0] adc_data0_i,
    input  logic [DW-1:0] adc_data1_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res0_o,
    output logic [DW-1:0] res1_o,
    output logic          busy_o,
    output logic          timeout_o,
    output logic          overrun_o
`ifdef ADC_ACQ_MINMAX_EN
    ,
    output logic [DW-1:0] min0_o,
    output logic [DW-1:0] max0_o,
    output logic [DW-1:0] min1_o,
    output logic [DW-1:0] max1_o
`endif
);

    localparam int CW = AVG_LOG2 + 1;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

    acq_state_e    state;
    logic          cont_q;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wd;

    logic          start_ok;
    logic          run_upd;
    logic          burst_done;
    logic          wd_expire;
    logic          acc_clear;
    logic [DW-1:0] avg0;
    logic [DW-1:0] avg1;

    assign start_ok   = (state == IDLE) && start_i;
    assign run_upd    = (state == RUN) && adc_update_i;
    assign burst_done = run_upd && (cnt == CNT_LAST);
    assign wd_expire  = (state == RUN) && !adc_update_i && (wd == WD_LAST);
    assign acc_clear  = abort_i || start_ok || burst_done || wd_expire;

    assign adc_en_o = (state == RUN);
    assign busy_o   = (state != IDLE);

`ifdef ADC_ACQ_MINMAX_EN
    logic [DW-1:0] bmin0, bmax0, bmin1, bmax1;
`endif

    adc_acq_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_accum0 (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .clear     (acc_clear),
        .add       (run_upd),
        .data      (adc_data0_i),
        .avg       (avg0)
`ifdef ADC_ACQ_MINMAX_EN
        ,
        .burst_min (bmin0),
        .burst_max (bmax0)
`endif
    );

    adc_acq_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_accum1 (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .clear     (acc_clear),
        .add       (run_upd),
        .data      (adc_data1_i),
        .avg       (avg1)
`ifdef ADC_ACQ_MINMAX_EN
        ,
        .burst_min (bmin1),
        .burst_max (bmax1)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cont_q      <= 1'b0;
            cnt         <= '0;
            wd          <= '0;
            res_valid_o <= 1'b0;
            res0_o      <= '0;
            res1_o      <= '0;
            timeout_o   <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef ADC_ACQ_MINMAX_EN
            min0_o      <= '0;
            max0_o      <= '0;
            min1_o      <= '0;
            max1_o      <= '0;
`endif
        end else if (abort_i) begin
            state       <= IDLE;
            cnt         <= '0;
            wd          <= '0;
            res_valid_o <= 1'b0;
        end else begin
            // Handshake drops valid unless a new result loads later in this block.
            if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= RUN;
                        cont_q    <= cont_i;
                        cnt       <= '0;
                        wd        <= '0;
                        timeout_o <= 1'b0;
                        overrun_o <= 1'b0;
                    end
                end
                RUN: begin
                    if (wd_expire) begin
                        state     <= IDLE;
                        timeout_o <= 1'b1;
                        cnt       <= '0;
                        wd        <= '0;
                    end else if (adc_update_i) begin
                        wd <= '0;
                        if (burst_done) begin
                            cnt <= '0;
                            if (!res_valid_o || res_ready_i) begin
                                res_valid_o <= 1'b1;
                                res0_o      <= avg0;
                                res1_o      <= avg1;
`ifdef ADC_ACQ_MINMAX_EN
                                min0_o      <= bmin0;
                                max0_o      <= bmax0;
                                min1_o      <= bmin1;
                                max1_o      <= bmax1;
`endif
                            end else begin
                                overrun_o <= 1'b1;
                            end
                            if (!cont_q) begin
                                state <= HOLD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_valid_o && res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb/tb_adc_acq_ctrl.sv - scoreboard bench for adc_acq_ctrl with a burst-level reference model
module tb_adc_acq_ctrl;

    localparam int DW  = 12;
    localparam int AL  = 2;
    localparam int N   = 1 << AL;
    localparam int TO  = 64;
    localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2;

    logic clk, rst_ni, start_i, cont_i, abort_i, adc_en_o, adc_update_i;
    logic [DW-1:0] adc_data0_i, adc_data1_i, res0_o, res1_o;
    logic res_valid_o, res_ready_i, busy_o, timeout_o, overrun_o;
`ifdef ADC_ACQ_MINMAX_EN
    logic [DW-1:0] min0_o, max0_o, min1_o, max1_o;
`endif

    adc_acq_ctrl #(.DW(DW), .AVG_LOG2(AL), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .cont_i       (cont_i),
        .abort_i      (abort_i),
        .adc_en_o     (adc_en_o),
        .adc_update_i (adc_update_i),
        .adc_data0_i  (adc_data0_i),
        .adc_data1_i  (adc_data1_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res0_o       (res0_o),
        .res1_o       (res1_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .overrun_o    (overrun_o)
`ifdef ADC_ACQ_MINMAX_EN
        ,
        .min0_o       (min0_o),
        .max0_o       (max0_o),
        .min1_o       (min1_o),
        .max1_o       (max1_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r0, r1, mn0, mx0, mn1, mx1;
    } res_t;

    res_t          exp_q[$];
    logic [DW-1:0] s0[$];
    logic [DW-1:0] s1[$];
    int            m_state = S_IDLE;
    int            m_idle  = 0;
    bit            m_cont  = 0, m_to = 0, m_ov = 0;
    bit            mon_en  = 0;
    int            checks  = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t burst_result();
        res_t r;
        int sum0 = 0, sum1 = 0;
        r.mn0 = '1; r.mn1 = '1; r.mx0 = '0; r.mx1 = '0;
        foreach (s0[i]) begin
            sum0 += int'(s0[i]);
            sum1 += int'(s1[i]);
            if (s0[i] < r.mn0) r.mn0 = s0[i];
            if (s0[i] > r.mx0) r.mx0 = s0[i];
            if (s1[i] < r.mn1) r.mn1 = s1[i];
            if (s1[i] > r.mx1) r.mx1 = s1[i];
        end
        r.r0 = DW'(sum0 / N);
        r.r1 = DW'(sum1 / N);
        return r;
    endfunction

    // Reference behaviour at one clock edge; vpre is whether a result was outstanding before it.
    task automatic model_edge(input bit st, input bit ct, input bit ab, input bit upd,
                              input bit rdy, input bit vpre,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        if (!rst_ni) begin
            m_state = S_IDLE; m_to = 0; m_ov = 0; m_cont = 0;
            exp_q.delete(); s0.delete(); s1.delete();
        end else if (ab) begin
            m_state = S_IDLE;
            exp_q.delete(); s0.delete(); s1.delete();
        end else if (m_state == S_IDLE) begin
            if (st) begin
                m_state = S_RUN; m_cont = ct; m_idle = 0; m_to = 0; m_ov = 0;
                s0.delete(); s1.delete();
            end
        end else if (m_state == S_RUN) begin
            if (!upd && m_idle == TO - 1) begin
                m_to = 1; m_state = S_IDLE;
                s0.delete(); s1.delete();
            end else if (upd) begin
                m_idle = 0;
                s0.push_back(d0);
                s1.push_back(d1);
                if (s0.size() == N) begin
                    if (!vpre || rdy) exp_q.push_back(burst_result());
                    else m_ov = 1;
                    s0.delete(); s1.delete();
                    if (!m_cont) m_state = S_HOLD;
                end
            end else begin
                m_idle++;
            end
        end else if (vpre && rdy) begin
            m_state = S_IDLE;
        end
    endtask

    task automatic step(input bit st, input bit ct, input bit ab, input bit upd, input bit rdy,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit vpre;
        start_i = st; cont_i = ct; abort_i = ab; adc_update_i = upd; res_ready_i = rdy;
        adc_data0_i = d0; adc_data1_i = d1;
        vpre = (exp_q.size() != 0);
        @(posedge clk);
        model_edge(st, ct, ab, upd, rdy, vpre, d0, d1);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy, '0, '0);
    endtask

    task automatic upd(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit rdy);
        step(0, 0, 0, 1, rdy, d0, d1);
    endtask

    // Monitor: compares outputs against the model once per cycle, popping on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("res_valid", res_valid_o, exp_q.size() != 0);
            if (res_valid_o && exp_q.size() != 0) begin
                chk("res0", res0_o, exp_q[0].r0);
                chk("res1", res1_o, exp_q[0].r1);
`ifdef ADC_ACQ_MINMAX_EN
                chk("min0", min0_o, exp_q[0].mn0);
                chk("max0", max0_o, exp_q[0].mx0);
                chk("min1", min1_o, exp_q[0].mn1);
                chk("max1", max1_o, exp_q[0].mx1);
`endif
                if (res_ready_i) void'(exp_q.pop_front());
            end
            chk("busy", busy_o, m_state != S_IDLE);
            chk("adc_en", adc_en_o, m_state == S_RUN);
            chk("timeout", timeout_o, m_to);
            chk("overrun", overrun_o, m_ov);
        end
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        idle(0);
        idle(0);
        rst_ni = 1'b1;
        chk("rst_valid", res_valid_o, 0);
        chk("rst_res0", res0_o, 0);
        chk("rst_busy", busy_o, 0);
        mon_en = 1;

        // single shot averaging
        step(1, 0, 0, 0, 0, '0, '0);
        upd(100, 12'hFFF, 0);
        upd(200, 12'hFFF, 0);
        upd(300, 12'hFFF, 0);
        upd(400, 12'hFFF, 0);
        chk("ss_valid", res_valid_o, 1);
        chk("ss_res0", res0_o, 250);
        chk("ss_res1", res1_o, 12'hFFF);
        idle(0);
        chk("ss_hold_en", adc_en_o, 0);
        idle(1);
        idle(0);

        // truncation and backpressure
        step(1, 0, 0, 0, 0, '0, '0);
        upd(1, 0, 0); upd(1, 0, 0); upd(1, 0, 0); upd(2, 0, 0);
        chk("tr_res0", res0_o, 1);
        for (int i = 0; i < 10; i++) idle(0);
        idle(1);
        idle(0);
        chk("tr_busy", busy_o, 0);

        // strobes in IDLE are ignored
        for (int i = 0; i < 6; i++) upd(12'(i * 7), 12'(i), 0);

        // continuous with overrun, then same-cycle ready and completion
        step(1, 1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 8; i++) upd(12'(10 + i * 3), 12'(500 - i), 0);
        chk("ov_flag", overrun_o, 1);
        for (int i = 0; i < 3; i++) upd(12'(40 + i), 12'(90), 0);
        upd(43, 90, 1);
        chk("ov_load_valid", res_valid_o, 1);
        idle(1);
        idle(0);
        step(0, 0, 1, 0, 0, '0, '0);

        // watchdog
        step(1, 0, 0, 0, 0, '0, '0);
        n = 0;
        while (!timeout_o && n < 200) begin
            idle(0);
            n++;
        end
        chk("wd_cycles", n, TO);
        chk("wd_busy", busy_o, 0);
        step(1, 0, 0, 0, 0, '0, '0);
        chk("wd_cleared", timeout_o, 0);
        step(0, 0, 1, 0, 0, '0, '0);

        // abort mid-burst then a clean restart
        step(1, 0, 0, 0, 0, '0, '0);
        upd(1000, 77, 0); upd(2000, 77, 0);
        step(0, 0, 1, 0, 0, '0, '0);
        idle(0);
        step(1, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) upd(8, 8, 0);
        chk("ab_res0", res0_o, 8);
        idle(1);

        // reset while in HOLD
        step(1, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) upd(12'(300 + i), 12'(5), 0);
        rst_ni = 1'b0;
        idle(0);
        rst_ni = 1'b1;
        chk("hr_valid", res_valid_o, 0);
        chk("hr_res0", res0_o, 0);
        chk("hr_res1", res1_o, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit st, ct, ab, u, r;
            st = (m_state == S_IDLE) && ($urandom_range(0, 3) == 0);
            ct = ($urandom_range(0, 2) != 0);
            ab = ($urandom_range(0, 149) == 0);
            u  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 2) == 0);
            step(st, ct, ab, u, r, DW'($urandom), DW'($urandom));
        end
        step(0, 0, 1, 0, 0, '0, '0);
        idle(0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_acq_ctrl.md
Name: adc_acq_ctrl

Overview:
- Acquisition scheduler for the dual-channel serial ADC interface. It gates the ADC enable and collects a burst of 2^AVG_LOG2 conversions per channel.
- It averages each burst and delivers one result pair over a valid/ready handshake.
- Provides single-shot and continuous modes, an abort, a no-data watchdog and overrun detection.
- Sits between the ADC SPI front-end and the measurement/register logic.

Parameters:
- DW, 12, ADC sample width per channel.
- AVG_LOG2, 2, log2 of samples averaged per result; legal range 0..4.
- TIMEOUT_CYC, 1024, RUN cycles without adc_update_i before timeout; must be >= 2.

Ports:
- clk  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  start pulse; honoured only in IDLE
- cont_i  in  1  continuous mode; sampled when start_i is accepted
- abort_i  in  1  abort pulse
- adc_en_o  out  1  enable to the ADC front-end
- adc_update_i  in  1  new-sample strobe from the front-end
- adc_data0_i  in  DW  channel 0 sample
- adc_data1_i  in  DW  channel 1 sample
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted by consumer
- res0_o  out  DW  averaged channel 0
- res1_o  out  DW  averaged channel 1
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky watchdog flag
- overrun_o  out  1  sticky, a result was dropped

Behaviour:
- Reset (rst_ni low at clk edge): state IDLE; all outputs 0; accumulators, sample counter and watchdog cleared.
- States: IDLE, RUN, HOLD.
- IDLE:
  - adc_en_o = 0; adc_update_i is ignored (the front-end may still emit strobes).
  - On start_i: go to RUN; latch cont_i; clear accumulators, sample counter, watchdog, timeout_o and overrun_o.
- RUN:
  - adc_en_o = 1.
  - Each adc_update_i: acc0 += adc_data0_i, acc1 += adc_data1_i; sample counter increments; watchdog clears.
  - Accumulator width is DW+AVG_LOG2 (never overflows).
- Burst completion, on the 2^AVG_LOG2-th update:
  - Next edge: res0_o = (acc0 + adc_data0_i) >> AVG_LOG2 (truncating), same for res1_o; res_valid_o = 1.
  - Accumulators and counter clear. Latency is 1 cycle from the final strobe to valid.
  - Single-shot: go to HOLD.
  - Continuous: stay in RUN.
- Handshake:
  - When res_valid_o = 1, res0_o/res1_o are stable until res_valid_o & res_ready_i.
  - After the handshake, res_valid_o drops on the next edge unless a new result loads on the same edge.
- Continuous, completion while res_valid_o = 1:
  - If res_ready_i is 0 that cycle: new result dropped, old result held, overrun_o set.
  - If res_ready_i is 1 that cycle: new result loads, res_valid_o stays 1, no overrun.
- HOLD:
  - adc_en_o = 0; updates ignored.
  - Handshake returns to IDLE.
- Watchdog:
  - Increments every RUN cycle without an update.
  - If it equals TIMEOUT_CYC-1 and no update arrives that cycle: timeout_o = 1, go to IDLE, partial burst discarded.
  - A pending res_valid_o is kept until its handshake; a handshake in IDLE simply clears it.
- abort_i (any state): next edge goes to IDLE; adc_en_o = 0; res_valid_o = 0; partial burst discarded; sticky flags unchanged.
- Priority on the same cycle: reset > abort > timeout > burst completion > handshake.
- start_i outside IDLE: ignored. start_i together with abort_i: abort wins.
- busy_o is asserted in RUN and HOLD.

Optional Feature:
- ADC_ACQ_MINMAX_EN defined:
  - Adds outputs min0_o, max0_o, min1_o, max1_o (DW each), reset 0.
  - They hold the per-channel min/max of the samples in the burst that produced the current result, updated on the same edge as res0_o.
  - A dropped (overrun) burst does not update them.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package adc_acq_pkg holds:
  - state enum typedef acq_state_e {IDLE, RUN, HOLD};
  - localparam ADC_DW = 12;
  - localparam AVG_LOG2_MAX = 4.
- Sub-module adc_acq_accum, instantiated once per channel:
  - clear, add-on-strobe, and shifted average output;
  - min/max tracking when ADC_ACQ_MINMAX_EN is defined.
- FSM, watchdog, handshake and flags stay in the top module.

Test Plan:
- Averaging and single-shot:
  - Stimulus: AVG_LOG2=2; start; 4 updates with data0 = 100, 200, 300, 400 and data1 = 0xFFF x4.
  - Response: valid 1 cycle after the 4th strobe; res0=250, res1=0xFFF; adc_en_o low in HOLD.
- Truncation and backpressure:
  - Stimulus: data0 = 1, 1, 1, 2; res_ready_i held low 10 cycles, then high.
  - Response: res0=1, held stable and valid throughout; valid drops the cycle after the handshake; state returns to IDLE, busy_o=0.
- Continuous and overrun:
  - Stimulus: cont_i=1; ready low through two bursts.
  - Response: first result held unchanged; overrun_o=1.
  - Follow-up: ready and completion on the same cycle → new result loads, valid stays high, no additional overrun.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=64; start with no strobes.
  - Response: timeout_o=1 after exactly 64 RUN cycles; adc_en_o=0; busy_o=0; the next start clears timeout_o.
- Abort and reset:
  - Stimulus: abort after 2 of 4 updates; restart; 4 updates of 8.
  - Response: no valid after the abort; restart yields res0=8 with no residue from the first burst.
  - Stimulus: strobes in IDLE → ignored.
  - Stimulus: rst_ni low for 1 edge in HOLD → all outputs 0.
